usb_fifo_bridge: RTL and testbench
==================================

Name: usb_fifo_bridge

Overview:
Parametrised stream bridge between the EZ-USB 16-bit endpoint interface and a wide FIFO (DRAM or BRAM FIFO) running on ifclk.
- Input path: packs RATIO USB words into one FIFO word. The source is either the USB stream or an internal test-pattern generator running at a programmable rate.
- Output path: unpacks FIFO words back into USB words.
- Status: sticky error flags and a write-word counter for debug LEDs and host readback.

Parameters:
USB_WIDTH, 16, width of USB data words.
FIFO_WIDTH, 32, FIFO word width; must equal RATIO*USB_WIDTH with RATIO in 1..8.
DIV_WIDTH, 8, width of rate_div.

Ports:
ifclk  in  1  sole clock, all logic rising edge.
reset_n  in  1  asynchronous, active-low reset.
mode  in  2  0=USB input, 1=testgen full rate, 2=testgen divided, 3=input halted.
rate_div  in  DIV_WIDTH  mode 2: one test symbol every rate_div+1 cycles.
usb_do  in  USB_WIDTH  data from EZ-USB.
usb_do_valid  in  1  usb_do valid.
usb_do_ready  out  1  bridge accepts usb_do this cycle.
fifo_di  out  FIFO_WIDTH  packed write data.
fifo_wren  out  1  write request.
fifo_full  in  1  FIFO full.
fifo_wrerr  in  1  FIFO write error.
fifo_do  in  FIFO_WIDTH  FIFO read data.
fifo_empty  in  1  FIFO empty.
fifo_rden  out  1  read request.
fifo_rderr  in  1  FIFO read error.
usb_di  out  USB_WIDTH  data to EZ-USB.
usb_di_valid  out  1  usb_di valid.
usb_di_ready  in  1  EZ-USB accepts usb_di.
err_clr  in  1  clears sticky errors.
wrerr_sticky  out  1  latched fifo_wrerr.
rderr_sticky  out  1  latched fifo_rderr.
word_cnt  out  32  FIFO words written, wraps.

Behaviour:
- Reset values: every register and output is 0; usb_do_ready=0, fifo_wren=0, fifo_rden=0, usb_di_valid=0.
- Symbol acceptance:
  - A USB symbol is accepted when usb_do_valid && usb_do_ready.
  - A FIFO write is accepted when fifo_wren && !fifo_full.
  - A FIFO read is accepted when fifo_rden && !fifo_empty.
- Packer:
  - Little-endian: the first symbol goes to bits [USB_WIDTH-1:0], symbol k to slice k.
  - When slice RATIO-1 arrives, the full word is registered. fifo_wren rises the next cycle (latency 1).
  - fifo_di and fifo_wren are held unchanged until the write is accepted.
- Stall rule: usb_do_ready = (mode_r==0) && !(fifo_wren && fifo_full). The generator also advances only under the same stall condition. The next word may pack while one write is pending; no symbol is lost.
- mode_r is mode registered once. On any change of mode_r:
  - the partial pack (slice counter) is discarded;
  - the generator counter is reset to 0;
  - the divider is reset to 0;
  - a pending write still completes.
- Test generator:
  - Emits a USB_WIDTH-bit incrementing counter starting at 0.
  - Mode 1: one symbol per unstalled cycle.
  - Mode 2: one symbol when the divider equals rate_div, after which the divider returns to 0. rate_div=0 equals mode 1.
  - The counter wraps modulo 2^USB_WIDTH.
- Mode 3: no input is accepted; the output path keeps running.
- Unpacker:
  - fifo_rden is a 1-cycle pulse, issued only when the unpack buffer is empty, no read is in flight, and !fifo_empty.
  - fifo_do is valid one cycle after the accepted read and is loaded into the buffer.
  - Slices are presented LSB-first on usb_di with usb_di_valid=1. Each slice is held until usb_di_ready.
  - After slice RATIO-1 is consumed, the buffer is empty.
- Sticky errors: each flag is set by its error input, cleared by err_clr. When set and clear occur in the same cycle, set wins.
- word_cnt increments on each accepted FIFO write.
- reset_n is asynchronous: assertion mid-transfer drops all partial and pending data immediately. Deassertion is synchronised internally with 2 flops; outputs stay at reset values until the synchroniser releases.

Optional Feature:
Macro: USB_FIFO_BRIDGE_TESTGEN_EN.
- Defined: the generator and rate divider are built; modes 1 and 2 behave as specified above.
- Undefined: generator logic is absent; modes 1 and 2 behave exactly like mode 3, and rate_div is ignored.

Test Plan:
- Reset, then mode=0 with USB words 0x1111, 0x2222 -> one fifo_wren with fifo_di=0x22221111; word_cnt=1.
- Mode 0, fifo_full held high for 5 cycles during a pending write -> fifo_di held; usb_do_ready=0 once the next word is packed; no symbol lost after release.
- Testgen defined, mode=2, rate_div=3 -> fifo words 0x00010000, 0x00030002, each symbol 4 cycles apart; undefined -> no fifo_wren.
- FIFO supplies 0xBBBBAAAA; usb_di_ready toggles 1,0,1 -> usb_di 0xAAAA then 0xBBBB; only one fifo_rden pulse.
- fifo_wrerr pulse coinciding with err_clr -> wrerr_sticky=1; err_clr alone next cycle -> 0.
- Mode switches 0->1 after one USB symbol, then reset_n pulsed mid-unpack -> partial discarded, first test word 0x00010000; all outputs 0 during reset.

Source files
------------

// File: rtl/usb_fifo_bridge.sv
// Stream bridge between the EZ-USB 16-bit endpoint interface and a wide FIFO on ifclk.
// Define USB_FIFO_BRIDGE_TESTGEN_EN to build the test-pattern generator and rate divider.
module usb_fifo_bridge #(
    parameter int unsigned USB_WIDTH  = 16,
    parameter int unsigned FIFO_WIDTH = 32,
    parameter int unsigned DIV_WIDTH  = 8
) (
    input  logic                  ifclk,
    input  logic                  reset_n,
    input  logic [1:0]            mode,
    input  logic [DIV_WIDTH-1:0]  rate_div,
    input  logic [USB_WIDTH-1:0]  usb_do,
    input  logic                  usb_do_valid,
    output logic                  usb_do_ready,
    output logic [FIFO_WIDTH-1:0] fifo_di,
    output logic                  fifo_wren,
    input  logic                  fifo_full,
    input  logic                  fifo_wrerr,
    input  logic [FIFO_WIDTH-1:0] fifo_do,
    input  logic                  fifo_empty,
    output logic                  fifo_rden,
    input  logic                  fifo_rderr,
    output logic [USB_WIDTH-1:0]  usb_di,
    output logic                  usb_di_valid,
    input  logic                  usb_di_ready,
    input  logic                  err_clr,
    output logic                  wrerr_sticky,
    output logic                  rderr_sticky,
    output logic [31:0]           word_cnt
);

    localparam int unsigned RATIO = FIFO_WIDTH / USB_WIDTH;
    localparam int unsigned CNT_W = (RATIO > 1) ? $clog2(RATIO) : 1;
    localparam logic [CNT_W-1:0] LAST_SLICE = CNT_W'(RATIO - 1);
    localparam logic [1:0] MODE_USB = 2'd0;
`ifdef USB_FIFO_BRIDGE_TESTGEN_EN
    localparam logic [1:0] MODE_GEN = 2'd1;
    localparam logic [1:0] MODE_DIV = 2'd2;
`endif

    typedef enum logic [1:0] {
        UP_IDLE,
        UP_REQ,
        UP_LOAD,
        UP_DRAIN
    } up_state_e;

    logic [1:0]            rst_sync_q;
    logic                  rst_n_i;
    logic                  en_q;

    logic [1:0]            mode_q;
    logic [1:0]            mode_d;
    logic                  mode_chg_c;

    logic                  stall_c;
    logic                  usb_ready_c;
    logic                  sym_vld_c;
    logic [USB_WIDTH-1:0]  sym_c;

    logic [CNT_W-1:0]      slice_q;
    logic [CNT_W-1:0]      slice_d;
    logic [FIFO_WIDTH-1:0] pack_q;
    logic [FIFO_WIDTH-1:0] pack_d;
    logic [FIFO_WIDTH-1:0] word_c;
    logic [FIFO_WIDTH-1:0] wr_data_q;
    logic [FIFO_WIDTH-1:0] wr_data_d;
    logic                  wren_q;
    logic                  wren_d;
    logic [31:0]           word_cnt_q;
    logic [31:0]           word_cnt_d;
    logic                  wrerr_q;
    logic                  wrerr_d;
    logic                  rderr_q;
    logic                  rderr_d;

    up_state_e             up_state_q;
    up_state_e             up_state_d;
    logic [FIFO_WIDTH-1:0] ubuf_q;
    logic [FIFO_WIDTH-1:0] ubuf_d;
    logic [CNT_W-1:0]      uidx_q;
    logic [CNT_W-1:0]      uidx_d;

`ifdef USB_FIFO_BRIDGE_TESTGEN_EN
    logic [USB_WIDTH-1:0]  gen_q;
    logic [USB_WIDTH-1:0]  gen_d;
    logic [DIV_WIDTH-1:0]  div_q;
    logic [DIV_WIDTH-1:0]  div_d;
`else
    logic                  unused_rate_div;
    assign unused_rate_div = ^rate_div;
`endif

    // Reset asserts asynchronously and releases two ifclk edges after reset_n rises.
    always_ff @(posedge ifclk or negedge reset_n) begin
        if (!reset_n) begin
            rst_sync_q <= 2'b00;
        end else begin
            rst_sync_q <= {rst_sync_q[0], 1'b1};
        end
    end

    assign rst_n_i = rst_sync_q[1];

    // Symbol source: USB handshake or internal generator, both frozen while a write is blocked.
    always_comb begin
        mode_d      = mode;
        mode_chg_c  = (mode != mode_q);
        stall_c     = wren_q && fifo_full;
        usb_ready_c = en_q && (mode_q == MODE_USB) && !stall_c;
        sym_vld_c   = usb_ready_c && usb_do_valid;
        sym_c       = usb_do;
`ifdef USB_FIFO_BRIDGE_TESTGEN_EN
        gen_d = gen_q;
        div_d = div_q;
        if (en_q && !stall_c) begin
            if (mode_q == MODE_GEN) begin
                sym_vld_c = 1'b1;
                sym_c     = gen_q;
                gen_d     = gen_q + USB_WIDTH'(1);
            end else if (mode_q == MODE_DIV) begin
                if (div_q == rate_div) begin
                    sym_vld_c = 1'b1;
                    sym_c     = gen_q;
                    gen_d     = gen_q + USB_WIDTH'(1);
                    div_d     = '0;
                end else begin
                    div_d = div_q + DIV_WIDTH'(1);
                end
            end
        end
        if (mode_chg_c) begin
            gen_d = '0;
            div_d = '0;
        end
`endif
    end

    // Packer: symbols shift in from the top so the first lands in the lowest slice.
    always_comb begin
        slice_d    = slice_q;
        pack_d     = pack_q;
        wr_data_d  = wr_data_q;
        wren_d     = wren_q;
        word_cnt_d = word_cnt_q;
        wrerr_d    = wrerr_q;
        rderr_d    = rderr_q;
        word_c     = (pack_q >> USB_WIDTH) |
                     (FIFO_WIDTH'(sym_c) << (FIFO_WIDTH - USB_WIDTH));

        if (wren_q && !fifo_full) begin
            wren_d     = 1'b0;
            word_cnt_d = word_cnt_q + 32'd1;
        end

        if (sym_vld_c) begin
            if (slice_q == LAST_SLICE) begin
                wr_data_d = word_c;
                wren_d    = 1'b1;
                slice_d   = '0;
                pack_d    = '0;
            end else begin
                pack_d  = word_c;
                slice_d = slice_q + CNT_W'(1);
            end
        end

        // A mode change drops the partial word; an already registered write still completes.
        if (mode_chg_c) begin
            slice_d = '0;
            pack_d  = '0;
        end

        if (fifo_wrerr) begin
            wrerr_d = 1'b1;
        end else if (err_clr) begin
            wrerr_d = 1'b0;
        end
        if (fifo_rderr) begin
            rderr_d = 1'b1;
        end else if (err_clr) begin
            rderr_d = 1'b0;
        end
    end

    // Unpacker: one read per buffer, slices drained LSB-first.
    always_comb begin
        up_state_d = up_state_q;
        ubuf_d     = ubuf_q;
        uidx_d     = uidx_q;
        case (up_state_q)
            UP_IDLE: begin
                if (en_q && !fifo_empty) begin
                    up_state_d = UP_REQ;
                end
            end
            UP_REQ: begin
                up_state_d = fifo_empty ? UP_IDLE : UP_LOAD;
            end
            UP_LOAD: begin
                ubuf_d     = fifo_do;
                uidx_d     = '0;
                up_state_d = UP_DRAIN;
            end
            UP_DRAIN: begin
                if (usb_di_ready) begin
                    ubuf_d = ubuf_q >> USB_WIDTH;
                    uidx_d = uidx_q + CNT_W'(1);
                    if (uidx_q == LAST_SLICE) begin
                        uidx_d     = '0;
                        up_state_d = UP_IDLE;
                    end
                end
            end
            default: begin
                up_state_d = UP_IDLE;
            end
        endcase
    end

    always_ff @(posedge ifclk or negedge rst_n_i) begin
        if (!rst_n_i) begin
            en_q       <= 1'b0;
            mode_q     <= 2'd0;
            slice_q    <= '0;
            pack_q     <= '0;
            wr_data_q  <= '0;
            wren_q     <= 1'b0;
            word_cnt_q <= 32'd0;
            wrerr_q    <= 1'b0;
            rderr_q    <= 1'b0;
            up_state_q <= UP_IDLE;
            ubuf_q     <= '0;
            uidx_q     <= '0;
        end else begin
            en_q       <= 1'b1;
            mode_q     <= mode_d;
            slice_q    <= slice_d;
            pack_q     <= pack_d;
            wr_data_q  <= wr_data_d;
            wren_q     <= wren_d;
            word_cnt_q <= word_cnt_d;
            wrerr_q    <= wrerr_d;
            rderr_q    <= rderr_d;
            up_state_q <= up_state_d;
            ubuf_q     <= ubuf_d;
            uidx_q     <= uidx_d;
        end
    end

`ifdef USB_FIFO_BRIDGE_TESTGEN_EN
    always_ff @(posedge ifclk or negedge rst_n_i) begin
        if (!rst_n_i) begin
            gen_q <= '0;
            div_q <= '0;
        end else begin
            gen_q <= gen_d;
            div_q <= div_d;
        end
    end
`endif

    assign usb_do_ready = usb_ready_c;
    assign fifo_di      = wr_data_q;
    assign fifo_wren    = wren_q;
    assign fifo_rden    = (up_state_q == UP_REQ);
    assign usb_di       = ubuf_q[USB_WIDTH-1:0];
    assign usb_di_valid = (up_state_q == UP_DRAIN);
    assign wrerr_sticky = wrerr_q;
    assign rderr_sticky = rderr_q;
    assign word_cnt     = word_cnt_q;

endmodule

// File: tb/tb_usb_fifo_bridge.sv
// Scoreboard bench for usb_fifo_bridge: directed stimulus, expected FIFO writes and USB slices
// are queued by the stimulus and checked by a separate monitor.
module tb_usb_fifo_bridge;

    logic        ifclk = 1'b0;
    logic        reset_n = 1'b0;
    logic [1:0]  mode = 2'd0;
    logic [7:0]  rate_div = 8'd0;
    logic [15:0] usb_do = 16'd0;
    logic        usb_do_valid = 1'b0;
    logic        usb_do_ready;
    logic [31:0] fifo_di;
    logic        fifo_wren;
    logic        fifo_full = 1'b0;
    logic        fifo_wrerr = 1'b0;
    logic [31:0] fifo_do = 32'd0;
    logic        fifo_empty = 1'b1;
    logic        fifo_rden;
    logic        fifo_rderr = 1'b0;
    logic [15:0] usb_di;
    logic        usb_di_valid;
    logic        usb_di_ready = 1'b0;
    logic        err_clr = 1'b0;
    logic        wrerr_sticky;
    logic        rderr_sticky;
    logic [31:0] word_cnt;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int rden_cnt = 0;
    logic [31:0] exp_wr[$];
    logic [15:0] exp_di[$];
    logic [31:0] src[$];
    int          wr_times[$];

`ifdef USB_FIFO_BRIDGE_TESTGEN_EN
    localparam bit TG = 1'b1;
`else
    localparam bit TG = 1'b0;
`endif

    usb_fifo_bridge dut (
        .ifclk(ifclk), .reset_n(reset_n), .mode(mode), .rate_div(rate_div),
        .usb_do(usb_do), .usb_do_valid(usb_do_valid), .usb_do_ready(usb_do_ready),
        .fifo_di(fifo_di), .fifo_wren(fifo_wren), .fifo_full(fifo_full),
        .fifo_wrerr(fifo_wrerr), .fifo_do(fifo_do), .fifo_empty(fifo_empty),
        .fifo_rden(fifo_rden), .fifo_rderr(fifo_rderr), .usb_di(usb_di),
        .usb_di_valid(usb_di_valid), .usb_di_ready(usb_di_ready), .err_clr(err_clr),
        .wrerr_sticky(wrerr_sticky), .rderr_sticky(rderr_sticky), .word_cnt(word_cnt)
    );

    always #5 ifclk = ~ifclk;
    always @(posedge ifclk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: pops the scoreboard whenever a transfer is accepted on either side.
    always @(negedge ifclk) begin
        if (fifo_wren && !fifo_full) begin
            if (exp_wr.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL wr_unexpected: got %h expected no write", fifo_di);
            end else begin
                chk("wr_data", fifo_di, exp_wr.pop_front());
            end
            wr_times.push_back(cyc);
        end
        if (usb_di_valid && usb_di_ready) begin
            if (exp_di.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL di_unexpected: got %h expected no slice", usb_di);
            end else begin
                chk("usb_di", 32'(usb_di), 32'(exp_di.pop_front()));
            end
        end
        if (fifo_rden) rden_cnt++;
    end

    // FIFO read model: data appears one cycle after an accepted read.
    initial begin
        logic acc;
        forever begin
            @(negedge ifclk);
            acc = fifo_rden && !fifo_empty;
            @(posedge ifclk);
            #1;
            if (acc && src.size() > 0) fifo_do = src.pop_front();
            fifo_empty = (src.size() == 0);
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge ifclk);
            #1;
        end
    endtask

    task automatic send_usb(input logic [15:0] w);
        bit done;
        done = 1'b0;
        usb_do = w;
        usb_do_valid = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(negedge ifclk);
            if (usb_do_ready) begin
                done = 1'b1;
                break;
            end
        end
        @(posedge ifclk);
        #1;
        usb_do_valid = 1'b0;
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL send_usb_timeout: got ready=0 expected ready=1 for %h", w);
        end
    endtask

    task automatic wait_sb(input string name, input int maxc);
        int n;
        n = 0;
        while ((exp_wr.size() != 0 || exp_di.size() != 0) && n < maxc) begin
            @(posedge ifclk);
            n++;
        end
        #1;
        chk(name, 32'(exp_wr.size() + exp_di.size()), 32'd0);
    endtask

    task automatic wait_di_valid(input string name);
        for (int i = 0; i < 20; i++) begin
            @(negedge ifclk);
            if (usb_di_valid) break;
        end
        chk(name, 32'(usb_di_valid), 32'd1);
    endtask

    task automatic chk_zero(input string name);
        chk({name, "_ctl"}, {26'd0, fifo_wren, fifo_rden, usb_di_valid, usb_do_ready,
                             wrerr_sticky, rderr_sticky}, 32'd0);
        chk({name, "_fifo_di"}, fifo_di, 32'd0);
        chk({name, "_usb_di"}, 32'(usb_di), 32'd0);
        chk({name, "_word_cnt"}, word_cnt, 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset and synchroniser release
        tick(3);
        @(negedge ifclk);
        chk_zero("reset");
        @(posedge ifclk);
        #1;
        reset_n = 1'b1;
        @(negedge ifclk);
        chk_zero("sync_hold");
        tick(4);
        @(negedge ifclk);
        chk("ready_after_release", 32'(usb_do_ready), 32'd1);
        @(posedge ifclk);
        #1;

        // Basic pack
        exp_wr.push_back(32'h22221111);
        send_usb(16'h1111);
        send_usb(16'h2222);
        wait_sb("t1_drain", 20);
        tick(1);
        chk("t1_word_cnt", word_cnt, 32'd1);

        // Write blocked by fifo_full
        fifo_full = 1'b1;
        send_usb(16'h3333);
        send_usb(16'h4444);
        usb_do = 16'h5555;
        usb_do_valid = 1'b1;
        repeat (5) begin
            @(negedge ifclk);
            chk("stall_ready", 32'(usb_do_ready), 32'd0);
            chk("stall_di", fifo_di, 32'h44443333);
            chk("stall_wren", 32'(fifo_wren), 32'd1);
        end
        @(posedge ifclk);
        #1;
        exp_wr.push_back(32'h44443333);
        exp_wr.push_back(32'h66665555);
        fifo_full = 1'b0;
        send_usb(16'h5555);
        send_usb(16'h6666);
        wait_sb("t2_drain", 20);
        tick(1);
        chk("t2_word_cnt", word_cnt, 32'd3);

        // Divided test generator
        wr_times.delete();
        rate_div = 8'd3;
        mode = 2'd2;
        if (TG) begin
            exp_wr.push_back(32'h00010000);
            exp_wr.push_back(32'h00030002);
            wait_sb("t3_drain", 60);
            mode = 2'd3;
            tick(3);
            chk("t3_nwr", 32'(wr_times.size()), 32'd2);
            if (wr_times.size() == 2) chk("t3_gap", 32'(wr_times[1] - wr_times[0]), 32'd8);
            chk("t3_word_cnt", word_cnt, 32'd5);
        end else begin
            tick(40);
            mode = 2'd3;
            tick(3);
            chk("t3_nwr", 32'(wr_times.size()), 32'd0);
            chk("t3_word_cnt", word_cnt, 32'd3);
        end

        // Unpack with usb_di_ready toggling
        exp_di.push_back(16'hAAAA);
        exp_di.push_back(16'hBBBB);
        src.push_back(32'hBBBBAAAA);
        wait_di_valid("t4_valid");
        @(posedge ifclk);
        #1;
        usb_di_ready = 1'b1;
        tick(1);
        usb_di_ready = 1'b0;
        tick(1);
        usb_di_ready = 1'b1;
        tick(1);
        usb_di_ready = 1'b0;
        wait_sb("t4_drain", 10);
        tick(4);
        chk("t4_rden_pulses", 32'(rden_cnt), 32'd1);
        chk("t4_valid_low", 32'(usb_di_valid), 32'd0);

        // Sticky errors
        fifo_wrerr = 1'b1;
        err_clr = 1'b1;
        tick(1);
        chk("wrerr_set_wins", 32'(wrerr_sticky), 32'd1);
        fifo_wrerr = 1'b0;
        tick(1);
        chk("wrerr_clr", 32'(wrerr_sticky), 32'd0);
        err_clr = 1'b0;
        fifo_rderr = 1'b1;
        tick(1);
        fifo_rderr = 1'b0;
        tick(1);
        chk("rderr_held", 32'(rderr_sticky), 32'd1);
        err_clr = 1'b1;
        tick(1);
        err_clr = 1'b0;
        chk("rderr_clr", 32'(rderr_sticky), 32'd0);

        // Mode switch drops partial word, then async reset mid-unpack
        mode = 2'd0;
        tick(2);
        send_usb(16'h7777);
        mode = 2'd1;
        fifo_full = 1'b1;
        tick(8);
        chk("t6_wren", 32'(fifo_wren), TG ? 32'd1 : 32'd0);
        if (TG) chk("t6_first_word", fifo_di, 32'h00010000);
        src.push_back(32'hDDDDCCCC);
        wait_di_valid("t6_valid");
        chk("t6_slice0", 32'(usb_di), 32'h0000CCCC);
        @(posedge ifclk);
        #3;
        reset_n = 1'b0;
        #1;
        chk_zero("async_reset");
        tick(3);
        chk_zero("reset_hold");
        reset_n = 1'b1;
        @(negedge ifclk);
        chk_zero("resync_hold");
        tick(8);
        chk("t6r_wren", 32'(fifo_wren), TG ? 32'd1 : 32'd0);
        if (TG) begin
            chk("t6r_first_word", fifo_di, 32'h00010000);
            exp_wr.push_back(32'h00010000);
        end
        chk("t6r_word_cnt0", word_cnt, 32'd0);
        mode = 2'd3;
        fifo_full = 1'b0;
        wait_sb("t6_drain", 20);
        tick(4);
        chk("t6r_word_cnt", word_cnt, TG ? 32'd1 : 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
